alu_input_sequencer: RTL and testbench
======================================

# alu_input_sequencer

Front-end sequencer that drives the ALU operand/opcode loader. It consumes a word stream (typically from the UART receiver) with a valid/ready handshake and emits three single-cycle load strobes in the fixed order A, B, opcode on a shared data bus. It then samples the ALU result and presents it on a valid/ready output stream toward the transmitter. It is the writer for the operand loader's bus and sits between the serial receive path and the ALU register stage.

## Interface

Parameters:
- DATA_WIDTH, 8: operand and result width.
- MODE_WIDTH, 6: opcode width.
- BUS_WIDTH, max(DATA_WIDTH, MODE_WIDTH): input word and data bus width (localparam).
- TIMEOUT_CYCLES, 1024: idle limit between words of one operation; used only with ALU_SEQ_TIMEOUT_EN.

Ports:
- i_clk, in, 1: clock; all state changes on the rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- i_rx_data, in, BUS_WIDTH: incoming word.
- i_rx_valid, in, 1: i_rx_data valid.
- o_rx_ready, out, 1: sequencer accepts a word.
- o_data_bus, out, BUS_WIDTH: registered copy of the last accepted word.
- o_load_A, out, 1: one-cycle strobe; bus holds operand A.
- o_load_B, out, 1: one-cycle strobe; bus holds operand B.
- o_load_op, out, 1: one-cycle strobe; bus holds opcode.
- i_alu_result, in, DATA_WIDTH, signed: combinational ALU output.
- o_tx_data, out, DATA_WIDTH: captured result.
- o_tx_valid, out, 1: o_tx_data valid.
- i_tx_ready, in, 1: downstream accepts the result.
- o_busy, out, 1: high in every state except WAIT_A.
- o_timeout, out, 1: one-cycle pulse when a partial operation is aborted. Tied 0 without the macro.

## Operation

- States: WAIT_A, LOAD_A, WAIT_B, LOAD_B, WAIT_OP, LOAD_OP, SETTLE, SEND.
- Transitions:
  - WAIT_A → LOAD_A → WAIT_B → LOAD_B → WAIT_OP → LOAD_OP → SETTLE → SEND → WAIT_A.
  - WAIT_x → LOAD_x only on handshake (i_rx_valid & o_rx_ready at the edge). Otherwise stay.
  - LOAD_x and SETTLE last exactly one cycle.
  - SEND exits when i_tx_ready is high at an edge.
- o_rx_ready is decoded from state only: high in WAIT_A, WAIT_B and WAIT_OP. It never depends on i_rx_valid.
- On handshake, o_data_bus is loaded with i_rx_data unmodified. It holds that value until the next handshake. The loader truncates it to DATA_WIDTH or MODE_WIDTH.
- Exactly one load strobe is high at a time. Strobes are registered and high only in their LOAD state.
- SETTLE gives the ALU one full cycle after the opcode is registered. At the SETTLE→SEND edge, o_tx_data <= i_alu_result and o_tx_valid <= 1.
- o_tx_data and o_tx_valid are stable while i_tx_ready is low. o_tx_valid clears on the accepting edge.
- Reset values: state WAIT_A, o_data_bus 0, all strobes 0, o_tx_data 0, o_tx_valid 0, o_timeout 0, timeout counter 0.
- Reset mid-operation discards the partial sequence and issues no strobe. The loader's registers keep their old values. The next accepted word is operand A.

## Timing

- For a handshake in cycle k, the matching strobe is high in cycle k+1 only.
- Minimum spacing between accepted words is 2 cycles (WAIT, LOAD).
- Opcode handshake in cycle k:
  - o_load_op high in cycle k+1.
  - SETTLE in cycle k+2.
  - o_tx_valid high from cycle k+3.
- If i_tx_ready is already high in the first SEND cycle, the result is accepted that edge. o_rx_ready is high in the next cycle.
- Back-to-back operation latency with no backpressure is 8 cycles.

## Configuration

- ALU_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT_B and WAIT_OP and clears on entering either state.
  - If no handshake occurs in TIMEOUT_CYCLES consecutive cycles, the FSM goes to WAIT_A at the edge ending the last cycle. o_timeout pulses high for one cycle and no strobe is issued.
  - A handshake in that final cycle takes priority over the timeout.
  - WAIT_A and SEND never time out.
- ALU_SEQ_TIMEOUT_EN undefined: there is no counter, the FSM waits indefinitely in the WAIT states, and o_timeout is constant 0.

## Test plan

- Words A=0x05, B=0x03, op=0x20 (ADD), with a behavioural loader+ALU and i_tx_ready=1:
  - o_load_A, o_load_B and o_load_op each pulse once, with o_data_bus 0x05, 0x03, 0x20 respectively.
  - o_tx_data=0x08, with o_tx_valid 3 cycles after the op handshake.
- A=0xF0, B=0x04, op=0x22 (SUB) → o_tx_data=0xEC (-20).
- i_rx_valid held high with words 1, 2, 0x20 presented back-to-back:
  - Each word is accepted exactly once, 2 cycles apart.
  - o_rx_ready is low during LOAD, SETTLE and SEND.
- i_tx_ready held low for 10 cycles in SEND:
  - o_tx_valid stays high and o_tx_data is unchanged; o_rx_ready stays 0.
  - Result accepted on release; WAIT_A the next cycle.
- i_reset asserted after the A and B strobes:
  - All outputs go to 0 immediately and no o_load_op occurs.
  - The following words 0x02, 0x02, 0x20 produce o_tx_data=0x04.
- Macro defined, TIMEOUT_CYCLES=16, A accepted then silence:
  - o_timeout pulses once after 16 WAIT_B cycles and o_busy falls.
  - The next word strobes o_load_A.
- Macro undefined, same stimulus: no o_timeout after 1000 cycles and the FSM stays in WAIT_B.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// rtl/alu_input_sequencer.sv - word-stream to ALU load-strobe sequencer with result output stream
//
// Accepts three words (operand A, operand B, opcode) over a valid/ready stream,
// drives them onto a shared bus with one-cycle load strobes in that order,
// waits one settle cycle, captures the ALU result and offers it downstream.
//
// Optional feature macro: ALU_SEQ_TIMEOUT_EN (abort a partial operation after
// TIMEOUT_CYCLES idle cycles in WAIT_B / WAIT_OP; pulses o_timeout).
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_rx_data/valid       incoming word stream; o_rx_ready is the accept signal
//   o_data_bus            last accepted word, registered
//   o_load_A/B/op         one-cycle load strobes for the operand loader
//   i_alu_result          combinational ALU output (signed)
//   o_tx_data/valid       captured result stream; i_tx_ready accepts it
//   o_busy                high whenever an operation is in progress
//   o_timeout             one-cycle abort pulse (constant 0 without the macro)

module alu_input_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int MODE_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int BUS_WIDTH     = (DATA_WIDTH > MODE_WIDTH) ? DATA_WIDTH : MODE_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [BUS_WIDTH-1:0]         i_rx_data,
  input  logic                         i_rx_valid,
  output logic                         o_rx_ready,
  output logic [BUS_WIDTH-1:0]         o_data_bus,
  output logic                         o_load_A,
  output logic                         o_load_B,
  output logic                         o_load_op,
  input  logic signed [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0]        o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic                         o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A, LOAD_A, WAIT_B, LOAD_B, WAIT_OP, LOAD_OP, SETTLE, SEND
  } state_t;

  state_t state, state_next;
  logic   handshake;
  logic   expire;

  // Ready is a pure state decode so the upstream can never form a
  // combinational loop through valid.
  assign o_rx_ready = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
  assign handshake  = i_rx_valid & o_rx_ready;
  assign o_busy     = (state != WAIT_A);

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_q;
  logic             in_wait_mid;

  assign in_wait_mid = (state == WAIT_B) || (state == WAIT_OP);

  // Counter is zero on the first cycle of WAIT_B/WAIT_OP because every path
  // into those states passes through a LOAD state, which clears it. A
  // handshake in the final cycle wins over the abort.
  assign expire = in_wait_mid && !handshake &&
                  (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_cnt  <= in_wait_mid ? idle_cnt + 1'b1 : '0;
      timeout_q <= expire;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign expire = 1'b0;
  // Always false; written against the parameter so it stays referenced.
  assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next = state;
    case (state)
      WAIT_A:  if (handshake) state_next = LOAD_A;
      LOAD_A:  state_next = WAIT_B;
      WAIT_B: begin
        if (handshake)   state_next = LOAD_B;
        else if (expire) state_next = WAIT_A;
      end
      LOAD_B:  state_next = WAIT_OP;
      WAIT_OP: begin
        if (handshake)   state_next = LOAD_OP;
        else if (expire) state_next = WAIT_A;
      end
      LOAD_OP: state_next = SETTLE;
      SETTLE:  state_next = SEND;
      SEND:    if (i_tx_ready) state_next = WAIT_A;
      default: state_next = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= WAIT_A;
      o_data_bus <= '0;
      o_load_A   <= 1'b0;
      o_load_B   <= 1'b0;
      o_load_op  <= 1'b0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (handshake) o_data_bus <= i_rx_data;
      // Strobes are registered copies of "next state is LOAD_x", so each is
      // high exactly during its LOAD cycle.
      o_load_A  <= (state_next == LOAD_A);
      o_load_B  <= (state_next == LOAD_B);
      o_load_op <= (state_next == LOAD_OP);
      if (state == SETTLE) begin
        o_tx_data  <= $unsigned(i_alu_result);
        o_tx_valid <= 1'b1;
      end else if (state == SEND && i_tx_ready) begin
        o_tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// tb/tb_alu_input_sequencer.sv - self-checking bench for alu_input_sequencer

module tb_alu_input_sequencer;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        data_bus;
  logic              load_a, load_b, load_op;
  logic signed [7:0] alu_result;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              busy;
  logic              timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_a = 0, n_b = 0, n_op = 0, n_to = 0;
  int last_hs_a = -1;
  logic [7:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_input_sequencer #(.DATA_WIDTH(8), .MODE_WIDTH(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_data_bus(data_bus), .o_load_A(load_a), .o_load_B(load_b), .o_load_op(load_op),
    .i_alu_result(alu_result),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_timeout(timeout)
  );

  // Behavioural operand loader + ALU (loader is not reset by the sequencer)
  logic [7:0] a_reg = 8'h00, b_reg = 8'h00;
  logic [5:0] op_reg = 6'h00;
  always @(posedge clk) begin
    if (load_a)  a_reg  <= data_bus;
    if (load_b)  b_reg  <= data_bus;
    if (load_op) op_reg <= data_bus[5:0];
  end
  always_comb begin
    alu_result = '0;
    case (op_reg)
      6'h20: alu_result = a_reg + b_reg;
      6'h22: alu_result = a_reg - b_reg;
      6'h24: alu_result = a_reg & b_reg;
      6'h25: alu_result = a_reg | b_reg;
      default: alu_result = '0;
    endcase
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: strobe exclusivity, output-stream stability, scoreboard
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (load_a | load_b | load_op)
        chk("strobe onehot", int'(load_a) + int'(load_b) + int'(load_op), 1);
      n_a  += int'(load_a);
      n_b  += int'(load_b);
      n_op += int'(load_op);
      n_to += int'(timeout);
      if (prev_valid && !prev_ready) begin
        chk("hold valid", tx_valid, 1);
        chk("hold data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) chk("unexpected result", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", tx_data, e);
        end
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Entered just after a negedge; returns at the negedge of the LOAD cycle.
  task automatic send_word(input logic [7:0] w, input bit hold, input int kind, output int hs);
    #1;
    rx_data  = w;
    rx_valid = 1'b1;
    hs = -1;
    for (int i = 0; i < 64; i++) begin
      if (rx_ready) begin
        hs = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) begin
      chk("handshake wait", 0, 1);
      rx_valid = hold;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) rx_valid = 1'b0;
      @(negedge clk);
      chk("strobe A", load_a, kind == 0);
      chk("strobe B", load_b, kind == 1);
      chk("strobe op", load_op, kind == 2);
      chk("data bus", data_bus, w);
      chk("rx_ready in LOAD", rx_ready, 0);
    end
  endtask

  // Entered at the LOAD_OP negedge; returns at the first SEND negedge.
  task automatic wait_result(input int ho);
    int t;
    t = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        t = cyc;
        break;
      end
      chk("rx_ready in SETTLE", rx_ready, 0);
    end
    chk("result latency", t - ho, 3);
    chk("rx_ready in SEND", rx_ready, 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input logic [7:0] exp, input bit hold, input int bp, input int gap);
    int ha, hb, ho, ca, cb, co;
    logic [7:0] d;
    #1;
    sb.push_back(exp);
    ca = n_a; cb = n_b; co = n_op;
    tx_ready = (bp == 0);
    send_word(a, hold, 0, ha);
    if (hold && last_hs_a >= 0) chk("op spacing", ha - last_hs_a, 8);
    last_hs_a = hold ? ha : -1;
    repeat (gap) @(negedge clk);
    send_word(b, hold, 1, hb);
    chk("A-B spacing", hb - ha, (gap == 0) ? 2 : gap + 1);
    send_word({2'b00, op}, hold, 2, ho);
    chk("B-op spacing", ho - hb, 2);
    wait_result(ho);
    d = tx_data;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp valid", tx_valid, 1);
      chk("bp data", tx_data, d);
      chk("bp rx_ready", rx_ready, 0);
    end
    if (bp > 0) begin
      @(posedge clk);
      #1;
      tx_ready = 1'b1;
      @(negedge clk);
    end
    chk("A strobes", n_a - ca, 1);
    chk("B strobes", n_b - cb, 1);
    chk("op strobes", n_op - co, 1);
    if (!hold) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rx_ready after send", rx_ready, 1);
      chk("valid after send", tx_valid, 0);
      chk("busy after send", busy, 0);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp;
    bit         hold;
    int         bp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, ha, hb, tc, co;
    tbl[0] = '{8'h05, 8'h03, 6'h20, 8'h08, 1'b0, 0};
    tbl[1] = '{8'hF0, 8'h04, 6'h22, 8'hEC, 1'b0, 0};
    tbl[2] = '{8'h01, 8'h02, 6'h20, 8'h03, 1'b1, 0};
    tbl[3] = '{8'h0C, 8'h0A, 6'h24, 8'h08, 1'b1, 0};
    tbl[4] = '{8'h0C, 8'h0A, 6'h25, 8'h0E, 1'b0, 0};
    tbl[5] = '{8'h7F, 8'h01, 6'h20, 8'h80, 1'b0, 10};
    tbl[6] = '{8'h00, 8'h01, 6'h22, 8'hFF, 1'b0, 0};

    @(negedge clk);
    chk("reset data_bus", data_bus, 0);
    chk("reset strobes", {load_a, load_b, load_op}, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset timeout", timeout, 0);
    chk("reset busy", busy, 0);
    chk("reset rx_ready", rx_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, tbl[i].hold, tbl[i].bp, 0);

    // Reset after A and B strobes
    co = n_op;
    send_word(8'h05, 1'b0, 0, ha);
    send_word(8'h03, 1'b0, 1, hb);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst data_bus", data_bus, 0);
    chk("midrst strobes", {load_a, load_b, load_op}, 0);
    chk("midrst tx_data", tx_data, 0);
    chk("midrst tx_valid", tx_valid, 0);
    chk("midrst busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("no op strobe after reset", n_op - co, 0);
    @(negedge clk);
    run_op(8'h02, 8'h02, 6'h20, 8'h04, 1'b0, 0, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    #1;
    t0 = n_to;
    send_word(8'h11, 1'b0, 0, ha);
    tc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout) begin
        tc = cyc;
        break;
      end
    end
    chk("timeout cycle", tc - ha, 18);
    chk("busy at timeout", busy, 0);
    @(posedge clk);
    #1;
    chk("timeout pulses", n_to - t0, 1);
    @(negedge clk);
    chk("timeout one cycle", timeout, 0);
    run_op(8'h09, 8'h01, 6'h20, 8'h0A, 1'b0, 0, 0);
    #1;
    t0 = n_to;
    run_op(8'h07, 8'h03, 6'h22, 8'h04, 1'b0, 0, 16);
    #1;
    chk("handshake beats timeout", n_to - t0, 0);
`else
    #1;
    t0 = n_to;
    run_op(8'h11, 8'h05, 6'h22, 8'h0C, 1'b0, 0, 1000);
    #1;
    chk("no timeout", n_to - t0, 0);
`endif

    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
